// File: rtl/fpga_boot_sequencer.sv
// fpga_boot_sequencer
//
// Power-on / reset sequencer for the FPGA top level. It sits between the clock wizard, the board
// reset, the boot strap pads and x_heep_system.
//
// Sequence:
//  - Wait for a stable PLL lock.
//  - Latch the debounced boot straps.
//  - Hold the MCU in reset for a fixed window, then release it.
//  - Capture the program exit code and show pass/fail on a status LED.
//  - The program can be re-run from DONE without reprogramming the FPGA.
//
// Ports:
//   clk_i                 system clock (clock wizard output)
//   rst_ni                synchronous active-low reset
//   pll_locked_i          clock wizard lock, asynchronous
//   boot_select_i         raw strap pad, asynchronous
//   execute_from_flash_i  raw strap pad, asynchronous
//   exit_valid_i          MCU exit strobe (clk_i domain)
//   exit_value_i          MCU exit value
//   rerun_i               single-cycle program restart request (honoured in DONE only)
//   mcu_rst_no            active-low MCU reset, high only in RUN/DONE
//   boot_select_o         latched boot_select strap
//   execute_from_flash_o  latched execute_from_flash strap
//   exit_done_o           exit code captured
//   exit_code_o           captured exit value
//   state_o               current state encoding
//   status_led_o          status LED

module fpga_boot_sequencer #(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 256,
   parameter int unsigned DEBOUNCE_CYCLES    = 1024,
   parameter int unsigned RESET_HOLD_CYCLES  = 64,
   parameter int unsigned BLINK_CYCLES       = 2**24
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pll_locked_i,
   input  logic        boot_select_i,
   input  logic        execute_from_flash_i,
   input  logic        exit_valid_i,
   input  logic [31:0] exit_value_i,
   input  logic        rerun_i,
   output logic        mcu_rst_no,
   output logic        boot_select_o,
   output logic        execute_from_flash_o,
   output logic        exit_done_o,
   output logic [31:0] exit_code_o,
   output logic [2:0]  state_o,
   output logic        status_led_o
);

   // One shared phase counter covers both LOCK_STABLE and HOLD_RESET.
   localparam int unsigned CNT_MAX    = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                        LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int unsigned CNT_W      = $clog2(CNT_MAX) + 1;
   localparam int unsigned DEB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned BLINK_W    = $clog2(BLINK_CYCLES) + 1;
   localparam int unsigned FAST_BLINK = BLINK_CYCLES / 4;

   typedef enum logic [2:0] {
      StWaitLock    = 3'd0,
      StLockStable  = 3'd1,
      StStrapSample = 3'd2,
      StHoldReset   = 3'd3,
      StRun         = 3'd4,
      StDone        = 3'd5
   } state_e;

   // ---------------------------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic [SYNC_STAGES-1:0] bs_sync_q;
   logic [SYNC_STAGES-1:0] eff_sync_q;
   logic                   locked_s;
   logic [1:0]             strap_s;   // [0] boot_select, [1] execute_from_flash

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lock_sync_q <= '0;
         bs_sync_q   <= '0;
         eff_sync_q  <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
         bs_sync_q   <= {bs_sync_q[SYNC_STAGES-2:0], boot_select_i};
         eff_sync_q  <= {eff_sync_q[SYNC_STAGES-2:0], execute_from_flash_i};
      end
   end

   assign locked_s = lock_sync_q[SYNC_STAGES-1];
   assign strap_s  = {eff_sync_q[SYNC_STAGES-1], bs_sync_q[SYNC_STAGES-1]};

   // ---------------------------------------------------------------------------------------
   // Strap debouncers
   // The debounced value follows the synchronized one only after they have disagreed for
   // DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts the count.
   // ---------------------------------------------------------------------------------------
   logic [1:0]       deb_q, deb_d;
   logic [DEB_W-1:0] deb_cnt_q [2];
   logic [DEB_W-1:0] deb_cnt_d [2];

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         deb_cnt_d[i] = '0;
         if (strap_s[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = strap_s[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         deb_q <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------------------
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               exit_done_q, exit_done_d;
   logic [31:0]        exit_code_q, exit_code_d;
   logic               bs_q, bs_d;
   logic               eff_q, eff_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      exit_done_d = exit_done_q;
      exit_code_d = exit_code_q;
      bs_d        = bs_q;
      eff_d       = eff_q;

      // Lock loss wins over every other event. The latched straps are kept.
      if ((state_q != StWaitLock) && !locked_s) begin
         state_d     = StWaitLock;
         cnt_d       = '0;
         exit_done_d = 1'b0;
         exit_code_d = '0;
      end else begin
         case (state_q)
            StWaitLock: begin
               if (locked_s) begin
                  state_d = StLockStable;
                  cnt_d   = '0;
               end
            end
            StLockStable: begin
               if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                  state_d = StStrapSample;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StStrapSample: begin
               bs_d    = deb_q[0];
               eff_d   = deb_q[1];
               state_d = StHoldReset;
               cnt_d   = '0;
            end
            StHoldReset: begin
               if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StRun: begin
               if (exit_valid_i) begin
                  exit_code_d = exit_value_i;
                  exit_done_d = 1'b1;
                  state_d     = StDone;
               end
            end
            StDone: begin
               if (rerun_i) begin
                  exit_code_d = '0;
                  exit_done_d = 1'b0;
                  state_d     = StStrapSample;
               end
            end
            default: begin
               // Encodings 6-7 are unreachable; recover through WAIT_LOCK.
               state_d = StWaitLock;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Registered output decode
   // Both mcu_rst_no and the LED are computed from state_d. This makes them change on the
   // same edge as the state register.
   // ---------------------------------------------------------------------------------------
   logic               mcu_rst_q, mcu_rst_d;
   logic               led_q, led_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

   always_comb begin
      mcu_rst_d   = (state_d == StRun) || (state_d == StDone);
      led_d       = 1'b0;
      blink_cnt_d = '0;

      if (state_d != state_q) begin
         // RUN starts dark; DONE starts lit for both pass and fail.
         led_d = (state_d == StDone);
      end else if (state_q == StRun) begin
         if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            led_d = ~led_q;
         end else begin
            led_d       = led_q;
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end else if (state_q == StDone) begin
         if (exit_code_q == '0) begin
            led_d = 1'b1;
         end else if (blink_cnt_q == BLINK_W'(FAST_BLINK - 1)) begin
            led_d = ~led_q;
         end else begin
            led_d       = led_q;
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StWaitLock;
         cnt_q       <= '0;
         exit_done_q <= 1'b0;
         exit_code_q <= '0;
         bs_q        <= 1'b0;
         eff_q       <= 1'b0;
         mcu_rst_q   <= 1'b0;
         led_q       <= 1'b0;
         blink_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exit_done_q <= exit_done_d;
         exit_code_q <= exit_code_d;
         bs_q        <= bs_d;
         eff_q       <= eff_d;
         mcu_rst_q   <= mcu_rst_d;
         led_q       <= led_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign mcu_rst_no           = mcu_rst_q;
   assign boot_select_o        = bs_q;
   assign execute_from_flash_o = eff_q;
   assign exit_done_o          = exit_done_q;
   assign exit_code_o          = exit_code_q;
   assign state_o              = state_q;
   assign status_led_o         = led_q;

endmodule

// File: doc/fpga_boot_sequencer.md
# fpga_boot_sequencer

Power-on/reset sequencer for the FPGA top level. It sits between the clock wizard, the board reset button, the boot strap pads and `x_heep_system`. It waits for a stable PLL lock, then samples and debounces the `boot_select`/`execute_from_flash` straps. It holds the MCU in reset for a fixed window, releases it, and captures the exit code when `exit_valid` fires. It also drives a status LED and supports re-running the program without reprogramming the FPGA.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked_i` and the strap pads (≥2).
- `LOCK_STABLE_CYCLES`, 256: consecutive locked cycles required before sequencing.
- `DEBOUNCE_CYCLES`, 1024: cycles a synchronized strap must be stable before its debounced value updates.
- `RESET_HOLD_CYCLES`, 64: cycles the MCU reset stays asserted after straps are latched.
- `BLINK_CYCLES`, 2**24: LED half-period in RUN. Must be a multiple of 4 and ≥4.

Ports:
- `clk_i` in 1: generated system clock (clock wizard output).
- `rst_ni` in 1: reset. **One clock; reset is synchronous and active-low.**
- `pll_locked_i` in 1: clock wizard lock, asynchronous.
- `boot_select_i` in 1: raw strap pad, asynchronous.
- `execute_from_flash_i` in 1: raw strap pad, asynchronous.
- `exit_valid_i` in 1: from `x_heep_system`, same clock domain.
- `exit_value_i` in 32: from `x_heep_system`.
- `rerun_i` in 1: single-cycle request to restart the program, same clock domain.
- `mcu_rst_no` out 1: reset to `x_heep_system`, active-low.
- `boot_select_o` out 1: latched strap to the MCU.
- `execute_from_flash_o` out 1: latched strap to the MCU.
- `exit_done_o` out 1: exit code captured.
- `exit_code_o` out 32: captured `exit_value_i`.
- `state_o` out 3: current state encoding.
- `status_led_o` out 1: status LED.

## Operation
State encodings: WAIT_LOCK=0, LOCK_STABLE=1, STRAP_SAMPLE=2, HOLD_RESET=3, RUN=4, DONE=5. Encodings 6–7 are unreachable; if entered, the next state is WAIT_LOCK.

Reset values (`rst_ni`=0 at a clock edge): state WAIT_LOCK, all counters 0, all synchronizer and debounce flops 0, and every output 0. That includes `mcu_rst_no`=0, so the MCU is held in reset.

Input conditioning:
- `locked_s` is `pll_locked_i` passed through `SYNC_STAGES` flops.
- Each strap passes through `SYNC_STAGES` flops, then a debouncer. The debounced value takes the synchronized value once that value has differed from the debounced value for `DEBOUNCE_CYCLES` consecutive cycles. The difference counter clears whenever the two agree.

State transitions:
- **WAIT_LOCK**: when `locked_s`=1, go to LOCK_STABLE and clear the counter.
- **LOCK_STABLE**: count cycles. After `LOCK_STABLE_CYCLES` cycles in this state, go to STRAP_SAMPLE.
- **STRAP_SAMPLE**: one cycle. Latch the debounced straps into `boot_select_o` and `execute_from_flash_o`, then go to HOLD_RESET.
- **HOLD_RESET**: after `RESET_HOLD_CYCLES` cycles, go to RUN.
- **RUN**: when `exit_valid_i`=1, capture `exit_value_i` into `exit_code_o`, set `exit_done_o`=1, and go to DONE.
- **DONE**: MCU remains out of reset. On `rerun_i`=1, clear `exit_done_o` and `exit_code_o` and go to STRAP_SAMPLE, which re-latches the straps.
- **Any state other than WAIT_LOCK**: if `locked_s`=0, go to WAIT_LOCK and clear counters, `exit_done_o` and `exit_code_o`. The latched straps keep their values. Lock loss has priority over every other event.

Ignored inputs:
- `rerun_i` outside DONE.
- `exit_valid_i` outside RUN.
- A strap change after STRAP_SAMPLE, until the next STRAP_SAMPLE.

Output decode:
- `mcu_rst_no` is registered and equals 1 exactly when the state register is RUN or DONE.
- `state_o` is the state register.
- `status_led_o` is registered:
  - 0 outside RUN/DONE.
  - RUN: toggles every `BLINK_CYCLES` cycles, starting from 0 on RUN entry.
  - DONE with `exit_code_o`==0: constant 1.
  - DONE with `exit_code_o`!=0: toggles every `BLINK_CYCLES/4` cycles, starting from 1 on DONE entry.
  - The blink counter clears on every state change.

Counter widths: `$clog2` of the parameter value + 1. Counters must not wrap within a state.

## Timing
- Lock to release: with `pll_locked_i` high from edge 1 onward, the state becomes RUN and `mcu_rst_no` rises at edge `SYNC_STAGES + 1 + LOCK_STABLE_CYCLES + 1 + RESET_HOLD_CYCLES`.
- Strap latch: the latched straps update at the edge leaving STRAP_SAMPLE and are stable before `mcu_rst_no` rises.
- Exit capture: `exit_valid_i` high at edge N gives `exit_done_o`=1, `exit_code_o` valid, and `state_o`=5 after edge N.
- Rerun: `rerun_i` at edge N gives `mcu_rst_no`=0 after edge N. The MCU is then held in reset for `1 + RESET_HOLD_CYCLES` cycles.
- Lock loss: `pll_locked_i` falling is visible `SYNC_STAGES` edges later. `mcu_rst_no` falls on the following edge.
- Reset: synchronous reset mid-operation returns every output to its reset value at the next edge.

## Test plan
Parameters for all tests: `SYNC_STAGES`=2, `LOCK_STABLE_CYCLES`=8, `DEBOUNCE_CYCLES`=4, `RESET_HOLD_CYCLES`=4, `BLINK_CYCLES`=8.

1. Boot: `boot_select_i`=1 held, `pll_locked_i` raised before edge 1 → `state_o` steps 0,1,2,3,4; `mcu_rst_no` rises at edge 16; `boot_select_o`=1.
2. Strap glitch: `boot_select_i` pulsed high for 3 cycles before STRAP_SAMPLE → `boot_select_o`=0. A 4-cycle stable high → `boot_select_o`=1.
3. Lock drop: `pll_locked_i` pulsed low for 1 cycle during LOCK_STABLE → back to WAIT_LOCK, and the full LOCK_STABLE count restarts. Lock drop during RUN → `mcu_rst_no`=0 three edges later.
4. Exit pass/fail:
   - `exit_valid_i`=1 with `exit_value_i`=0 → `exit_done_o`=1, LED constant 1.
   - With `exit_value_i`=32'h1 → LED toggles every 2 cycles.
5. Rerun: `rerun_i` in DONE → `exit_done_o`=0, `exit_code_o`=0, `mcu_rst_no` low for 5 cycles, then RUN. `rerun_i` during RUN → no effect.
6. Simultaneous events and reset:
   - Lock loss and `exit_valid_i` in the same cycle → WAIT_LOCK, `exit_done_o` stays 0.
   - `rst_ni`=0 mid-RUN → all outputs 0 at the next edge.
